// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external 16-bit combinational ALU between N_REQ
//               requesters. A round-robin arbiter picks one request in IDLE,
//               latches its operands and opcode into the registers that drive
//               the ALU, captures the ALU output one cycle later, and presents
//               it on a valid/ready response channel tagged with the ID of the
//               requester that issued it.
//
// Ports       : clk, reset      clock, asynchronous active-high reset
//               req_valid/ready per-requester request handshake (one-hot ready)
//               req_a/b/sel     packed per-requester operands and opcode
//               alu_a/b/sel     operand registers driving the shared ALU
//               alu_result      combinational ALU output
//               resp_valid/ready/data/id  response channel
//               busy            high whenever the FSM is not idle
//               op_count        completed-response counter (wraps at 16 bits)
//
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [3*N_REQ-1:0]   req_sel,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [2:0]           alu_sel,
    input  logic [15:0]          alu_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [15:0]          resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [15:0]       r_alu_a;
    logic [15:0]       r_alu_b;
    logic [2:0]        r_alu_sel;
    logic [15:0]       r_resp_data;
    logic [ID_W-1:0]   r_resp_id;
    logic              r_resp_valid;
    logic [15:0]       r_op_count;

    logic              w_found;
    logic [N_REQ-1:0]  w_win_onehot;
    logic [ID_W-1:0]   w_win_id;
    logic [PTR_W-1:0]  w_win_ptr_next;
    logic [15:0]       w_win_a;
    logic [15:0]       w_win_b;
    logic [2:0]        w_win_sel;

    logic              w_accept;

    // ------------------------------------------------------------------------
    // Round-robin winner search. The candidate list is walked twice: the first
    // lap only considers indices at or above rr_ptr, the second lap only those
    // below it, which yields the order rr_ptr..N_REQ-1, 0..rr_ptr-1 while
    // keeping every vector index a loop constant.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found        = 1'b0;
        w_win_onehot   = '0;
        w_win_id       = '0;
        w_win_ptr_next = '0;
        w_win_a        = '0;
        w_win_b        = '0;
        w_win_sel      = '0;
        for (int k = 0; k < 2 * N_REQ; k++) begin
            if (!w_found && req_valid[k % N_REQ] &&
                ((k < N_REQ) ? (PTR_W'(k % N_REQ) >= r_rr_ptr)
                             : (PTR_W'(k % N_REQ) <  r_rr_ptr))) begin
                w_found                    = 1'b1;
                w_win_onehot[k % N_REQ]    = 1'b1;
                w_win_id                   = ID_W'(k % N_REQ);
                w_win_ptr_next             = ((k % N_REQ) == N_REQ - 1) ? '0
                                             : PTR_W'((k % N_REQ) + 1);
                w_win_a                    = req_a[(k % N_REQ)*16 +: 16];
                w_win_b                    = req_b[(k % N_REQ)*16 +: 16];
                w_win_sel                  = req_sel[(k % N_REQ)*3 +: 3];
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found)    w_state_next = S_EXEC;
            S_EXEC:                  w_state_next = S_RESP;
            S_RESP:  if (resp_ready) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. req_ready is forced low during reset because the grant is
    // combinational and would otherwise follow req_valid while reset is held.
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (r_state == S_IDLE) begin
            if (!reset) begin
                req_ready = w_win_onehot;
            end
        end else begin
            busy = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, response capture, pointer and counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_valid <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_win_a;
                r_alu_b   <= w_win_b;
                r_alu_sel <= w_win_sel;
                r_resp_id <= w_win_id;
                r_rr_ptr  <= w_win_ptr_next;
            end
            if (r_state == S_EXEC) begin
                r_resp_data  <= alu_result;
                r_resp_valid <= 1'b1;
            end
            if ((r_state == S_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_op_count   <= r_op_count + 16'd1;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter. Includes a
//               behavioural model of the shared ALU driving alu_result.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [16*N_REQ-1:0]  req_a = '0;
    logic [16*N_REQ-1:0]  req_b = '0;
    logic [3*N_REQ-1:0]   req_sel = '0;
    logic [15:0]          alu_a;
    logic [15:0]          alu_b;
    logic [2:0]           alu_sel;
    logic [15:0]          alu_result;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [15:0]          resp_data;
    logic [ID_W-1:0]      resp_id;
    logic                 busy;
    logic [15:0]          op_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Shared ALU behaviour
    always_comb begin
        alu_result = 16'h0000;
        case (alu_sel)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = alu_a << alu_b[3:0];
            3'b110: alu_result = alu_a >> alu_b[3:0];
            default: alu_result = (alu_a > alu_b) ? 16'd1 : ((alu_a < alu_b) ? 16'd2 : 16'd0);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] sel);
        req_valid[id]        = 1'b1;
        req_a[id*16 +: 16]   = a;
        req_b[id*16 +: 16]   = b;
        req_sel[id*3 +: 3]   = sel;
    endtask

    // Single operation from an idle start, response taken immediately.
    task automatic run_op(input string tag, input int id, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] sel,
                          input logic [15:0] exp);
        req_valid = '0;
        set_req(id, a, b, sel);
        #1;
        check({tag, " grant"}, req_ready, 32'(1 << id));
        tick();
        req_valid = '0;
        tick();
        check({tag, " valid"}, resp_valid, 1);
        check({tag, " data"}, resp_data, exp);
        check({tag, " id"}, resp_id, id);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " done"}, resp_valid, 0);
    endtask

    initial begin
        // ---------------- reset and a single add from requester 0 ----------
        set_req(0, 16'h0005, 16'h0003, 3'b000);
        #2 reset = 1'b1;
        #1;
        check("rst req_ready", req_ready, 0);
        check("rst resp_valid", resp_valid, 0);
        check("rst op_count", op_count, 0);
        check("rst busy", busy, 0);
        check("rst alu_a", alu_a, 0);
        check("rst resp_id", resp_id, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("t1 grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("t1 exec busy", busy, 1);
        check("t1 exec ready", req_ready, 0);
        check("t1 exec alu_a", alu_a, 16'h0005);
        check("t1 exec alu_b", alu_b, 16'h0003);
        check("t1 exec resp_valid", resp_valid, 0);
        tick();
        check("t1 resp_valid", resp_valid, 1);
        check("t1 resp_data", resp_data, 16'h0008);
        check("t1 resp_id", resp_id, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t1 op_count", op_count, 1);
        check("t1 busy", busy, 0);
        check("t1 resp_valid low", resp_valid, 0);

        // ---------------- round-robin with four contending requesters ------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr after reset op_count", op_count, 0);
        for (int i = 0; i < N_REQ; i++) set_req(i, 16'h0010, 16'h0001, 3'b001);
        resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            check("rr grant", req_ready, 32'(1 << (g % N_REQ)));
            tick();
            check("rr exec ready", req_ready, 0);
            tick();
            check("rr resp_valid", resp_valid, 1);
            check("rr resp_data", resp_data, 16'h000F);
            check("rr resp_id", resp_id, g % N_REQ);
            if (g == 4) req_valid = '0;
            tick();
            check("rr idle", resp_valid, 0);
        end
        resp_ready = 1'b0;
        check("rr op_count", op_count, 5);

        // ---------------- back-pressure with a shl that overflows ----------
        set_req(2, 16'h8000, 16'h0001, 3'b101);
        #1;
        check("bp grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b1111;
            #1;
            check("bp resp_valid", resp_valid, 1);
            check("bp resp_data", resp_data, 16'h0000);
            check("bp resp_id", resp_id, 2);
            check("bp req_ready", req_ready, 0);
            check("bp op_count", op_count, 5);
            tick();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp busy", busy, 0);
        check("bp op_count", op_count, 6);

        // ---------------- opcode edge cases --------------------------------
        run_op("cmp lt",    1, 16'h0001, 16'hFFFF, 3'b111, 16'h0002);
        run_op("cmp eq",    3, 16'h1234, 16'h1234, 3'b111, 16'h0000);
        run_op("cmp gt",    0, 16'hFFFF, 16'h0001, 3'b111, 16'h0001);
        run_op("shr mod16", 2, 16'hF000, 16'h0014, 3'b110, 16'h0F00);
        run_op("sub wrap",  1, 16'h0000, 16'h0001, 3'b001, 16'hFFFF);
        run_op("add wrap",  0, 16'hFFFF, 16'h0002, 3'b000, 16'h0001);
        run_op("and",       3, 16'hF0F0, 16'h3C3C, 3'b010, 16'h3030);
        run_op("or",        2, 16'hF0F0, 16'h0F01, 3'b011, 16'hFFF1);
        run_op("xor",       1, 16'hAAAA, 16'hFFFF, 3'b100, 16'h5555);
        run_op("shl mod16", 0, 16'h0001, 16'h0011, 3'b101, 16'h0002);
        check("ops op_count", op_count, 16);

        // ---------------- reset during RESP --------------------------------
        req_valid = '0;
        set_req(1, 16'h0007, 16'h0002, 3'b000);
        tick();
        req_valid = '0;
        tick();
        check("mid resp_valid", resp_valid, 1);
        check("mid resp_id", resp_id, 1);
        #2 reset = 1'b1;
        req_valid = 4'b1010;
        set_req(3, 16'h00F0, 16'h000F, 3'b011);
        #1;
        check("mid rst resp_valid", resp_valid, 0);
        check("mid rst busy", busy, 0);
        check("mid rst op_count", op_count, 0);
        check("mid rst req_ready", req_ready, 0);
        check("mid rst alu_a", alu_a, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("post rst grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        tick();
        check("post rst id1", resp_id, 1);
        check("post rst data1", resp_data, 16'h0009);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post rst grant3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        check("post rst id3", resp_id, 3);
        check("post rst data3", resp_data, 16'h00FF);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post rst op_count", op_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
